bram_tdp_be: RTL
================

// Module: bram_tdp_be
// PURPOSE
//   True dual-port block RAM with per-byte write enables and per-port read-during-write mode.
//   Optional output pipeline register and per-port read-valid tracking.
//   Registered same-address collision flag.
//   Generic storage for LR-series datapaths (frame/line buffers, shared scratchpads).
//   Memory array infers to vendor BRAM.
//   Control and pipeline registers use async active-low reset.
// PARAMETERS
//   DATA_WIDTH    32            word width in bits; must be a multiple of BYTE_WIDTH
//   BYTE_WIDTH    8             write-enable granularity in bits
//   ADDR_BITS     10            address width; depth = 2**ADDR_BITS
//   WRITE_MODE_A  WM_READ_FIRST port A read-during-write mode (bram_pkg::write_mode_e)
//   WRITE_MODE_B  WM_READ_FIRST port B read-during-write mode
//   OUT_REG       1             0: read latency 1; 1: extra output register, latency 2
//   INIT_FILE     ""            $readmemh image; empty string = no init (contents X)
// PORTS
//   clk_i        in   1           single clock, both ports
//   rst_ni       in   1           async active-low reset
//   en_a_i       in   1           port A enable
//   we_a_i       in   NB_BYTES    port A byte write enables; NB_BYTES = DATA_WIDTH/BYTE_WIDTH
//   addr_a_i     in   ADDR_BITS   port A address
//   wdata_a_i    in   DATA_WIDTH  port A write data
//   rdata_a_o    out  DATA_WIDTH  port A read data
//   rvalid_a_o   out  1           port A read data valid, one cycle per access
//   en_b_i / we_b_i / addr_b_i / wdata_b_i / rdata_b_o / rvalid_b_o
//                                 port B, same widths and meanings
//   collision_o  out  1           registered pulse: same-address conflict occurred
// BEHAVIOUR
//   - Reset: rdata_*_o=0, rvalid_*_o=0, collision_o=0, all pipeline regs cleared.
//     Memory contents are never reset.
//     While rst_ni=0, no writes occur and no accesses are accepted.
//     Deasserting reset mid-operation drops in-flight reads; no rvalid is emitted for them.
//   - Access: cycle N with en=1 is one access.
//     we=0: read.
//     we!=0: write of the enabled bytes only; other bytes are unchanged.
//   - Read latency: OUT_REG=0 -> rdata/rvalid at N+1; OUT_REG=1 -> at N+2.
//     rvalid is high exactly one cycle per returning access.
//     rdata holds its last value when rvalid=0.
//   - Write data is applied directly (no input register).
//   - Per-port read-during-write (same port, we!=0):
//     WM_READ_FIRST: rdata = old word; rvalid asserted.
//     WM_WRITE_FIRST: rdata = merged new word (new enabled bytes, old others); rvalid asserted.
//     WM_NO_CHANGE: rdata holds; rvalid stays 0.
//   - en=0: port idle; rdata holds; rvalid=0 at the corresponding latency.
//   - Cross-port, same address, both en=1, cycle N:
//     Both write, overlapping bytes: port A data wins on overlapping bytes.
//     Non-overlapping bytes from both ports are written.
//     One writes, other reads: reader returns the OLD word.
//     Both read: no conflict; collision_o stays 0.
//     Any write involvement -> collision_o=1 at N+1 for one cycle.
//   - Addresses wrap naturally: the full 2**ADDR_BITS range is valid; no out-of-range case.
// STRUCTURE
//   - bram_pkg: typedef enum logic [1:0] write_mode_e {WM_READ_FIRST, WM_WRITE_FIRST, WM_NO_CHANGE}.
//     Also a function nb_bytes(DATA_WIDTH, BYTE_WIDTH).
//   - Sub-module bram_tdp_port_pipe, instantiated twice.
//     Holds per-port output register(s) and valid shift chain, parametrised by OUT_REG and mode.
//   - Memory array and the two write processes stay in the top module.
//     Byte loop per port; port A process ordered to win overlapping writes.
//     Collision compare is one registered equality plus enable terms.
//   - Elaboration check: $error if DATA_WIDTH % BYTE_WIDTH != 0.
// TESTING
//   1. Reset, then write A addr 0x005 = 0xDEADBEEF, we=4'hF; read A @0x005.
//      -> rdata_a=0xDEADBEEF with rvalid_a at N+2 (OUT_REG=1) / N+1 (OUT_REG=0).
//   2. Byte enables: we_b=4'b0101 wdata=0x11223344 over 0xDEADBEEF @0x005.
//      -> read gives 0xDE22BE44.
//   3. Same-port RDW on 0x005 (old 0xDE22BE44), write 0xCAFEF00D, we=4'hF:
//      READ_FIRST -> rdata=0xDE22BE44; WRITE_FIRST -> rdata=0xCAFEF00D; NO_CHANGE -> rvalid=0.
//   4. Both write @0x3FF same cycle, A=0xAAAAAAAA we=4'b0011, B=0xBBBBBBBB we=4'b0110.
//      -> mem=0x00BBAAAA-style merge with byte1 from A (word=0x??BBAAAA, byte3 unchanged).
//      -> collision_o pulse at N+1.
//   5. A reads @0x010 while B writes 0x12345678 there.
//      -> A returns old word; collision_o=1; a re-read returns 0x12345678.
//   6. Back-to-back reads then rst_ni pulled low mid-burst.
//      -> rdata/rvalid/collision go 0 immediately; no stale rvalid after release;
//         memory contents preserved.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared types and helpers for the byte-enabled true dual-port RAM.
// Provides the per-port read-during-write mode and the byte-lane count helper.
package bram_pkg;

  typedef enum logic [1:0] {
    WM_READ_FIRST,
    WM_WRITE_FIRST,
    WM_NO_CHANGE
  } write_mode_e;

  function automatic int nb_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/bram_tdp_port_pipe.sv
// bram_tdp_port_pipe: per-port read return path (data register, optional output register, valid chain).
//   clk_i, rst_ni     clock, async active-low reset
//   en_i, wr_i        access accepted this cycle, and whether it writes any byte
//   old_i, new_i      stored word before the access, and the word merged with this port's write bytes
//   rdata_o, rvalid_o returned data (holds between accesses) and one-cycle valid per returning access
module bram_tdp_port_pipe
  import bram_pkg::*;
#(
  parameter int          DW      = 32,
  parameter bit          OUT_REG = 1'b1,
  parameter write_mode_e MODE    = WM_READ_FIRST
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic [DW-1:0] old_i,
  input  logic [DW-1:0] new_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  logic          acc, v1;
  logic [DW-1:0] d1;

  // NO_CHANGE writes return nothing, so they never load data or raise valid.
  assign acc = en_i && !(MODE == WM_NO_CHANGE && wr_i);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= acc;
      if (acc) d1 <= (MODE == WM_WRITE_FIRST && wr_i) ? new_i : old_i;
    end

  if (OUT_REG) begin : g_oreg
    logic          v2;
    logic [DW-1:0] d2;
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    assign rdata_o  = d2;
    assign rvalid_o = v2;
  end else begin : g_direct
    assign rdata_o  = d1;
    assign rvalid_o = v1;
  end

endmodule

// File: rtl/bram_tdp_be.sv
// bram_tdp_be: true dual-port RAM with byte write enables, per-port read-during-write mode and collision flag.
module bram_tdp_be
  import bram_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          BYTE_WIDTH   = 8,
  parameter int          ADDR_BITS    = 10,
  parameter write_mode_e WRITE_MODE_A = WM_READ_FIRST,
  parameter write_mode_e WRITE_MODE_B = WM_READ_FIRST,
  parameter bit          OUT_REG      = 1'b1,
  parameter string       INIT_FILE    = "",
  localparam int         NB           = nb_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_a_i,
  input  logic [NB-1:0]         we_a_i,
  input  logic [ADDR_BITS-1:0]  addr_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic                  rvalid_a_o,
  input  logic                  en_b_i,
  input  logic [NB-1:0]         we_b_i,
  input  logic [ADDR_BITS-1:0]  addr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic                  rvalid_b_o,
  output logic                  collision_o
);
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk
    $error("bram_tdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;
  logic [NB-1:0]         wr_a, wr_b;
  assign old_a = mem[addr_a_i];
  assign old_b = mem[addr_b_i];
  assign wr_a  = we_a_i & {NB{en_a_i & rst_ni}};
  assign wr_b  = we_b_i & {NB{en_b_i & rst_ni}};
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (we_a_i[i]) new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_a_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (we_b_i[i]) new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_b_i[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++)
      if (wr_b[i]) mem[addr_b_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_b_i[i*BYTE_WIDTH +: BYTE_WIDTH];
    for (int i = 0; i < NB; i++)
      if (wr_a[i]) mem[addr_a_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_a_i[i*BYTE_WIDTH +: BYTE_WIDTH];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) collision_o <= 1'b0;
    else collision_o <= en_a_i && en_b_i && (addr_a_i == addr_b_i) && (|we_a_i || |we_b_i);
  bram_tdp_port_pipe #(.DW(DATA_WIDTH), .OUT_REG(OUT_REG), .MODE(WRITE_MODE_A)) u_pipe_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_a_i),
    .wr_i     (|we_a_i),
    .old_i    (old_a),
    .new_i    (new_a),
    .rdata_o  (rdata_a_o),
    .rvalid_o (rvalid_a_o)
  );
  bram_tdp_port_pipe #(.DW(DATA_WIDTH), .OUT_REG(OUT_REG), .MODE(WRITE_MODE_B)) u_pipe_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_b_i),
    .wr_i     (|we_b_i),
    .old_i    (old_b),
    .new_i    (new_b),
    .rdata_o  (rdata_b_o),
    .rvalid_o (rvalid_b_o)
  );
endmodule
